st_word_splitter: RTL and testbench

Avalon-ST width down-converter sitting directly downstream of the 36-bit timing adapter FIFO. It accepts one 36-bit word per handshake and emits it as two 18-bit beats on a registered ready/valid source. It drives the FIFO's `out_ready` and consumes its `out_valid`/`out_data`, converting to the 18-bit datapath of the next stage. A beat counter is exposed for status/debug.

---
 rtl/st_adapter_pkg.sv | 14 +
 rtl/st_word_splitter.sv | 124 ++++++++++++
 tb/tb_st_word_splitter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/st_adapter_pkg.sv
// Shared definitions for the Avalon-ST adapter stages.
// Provides the default datapath widths and the splitter state encoding.
package st_adapter_pkg;

    localparam int unsigned ST_IN_WIDTH  = 36;
    localparam int unsigned ST_OUT_WIDTH = 18;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } st_state_e;

endpackage

// File: rtl/st_word_splitter.sv
// Avalon-ST width down-converter: one IN_WIDTH word in, two OUT_WIDTH beats out.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_ready/in_valid/in_data    sink side (from the timing adapter FIFO)
//   out_ready/out_valid/out_data/out_last  registered source side
//   word_count              words fully delivered, wraps modulo 2^CNT_WIDTH
module st_word_splitter
    import st_adapter_pkg::*;
#(
    parameter int unsigned OUT_WIDTH = ST_OUT_WIDTH,
    parameter int unsigned IN_WIDTH  = ST_IN_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 in_ready,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [CNT_WIDTH-1:0] word_count
);

    if (IN_WIDTH != 2 * OUT_WIDTH) begin : g_width_check
        $error("st_word_splitter: IN_WIDTH must equal 2*OUT_WIDTH");
    end

    // Shift amounts selecting which half goes out first.
    localparam int unsigned FIRST_SHIFT  = MSB_FIRST ? OUT_WIDTH : 0;
    localparam int unsigned SECOND_SHIFT = MSB_FIRST ? 0 : OUT_WIDTH;

    st_state_e            state_q, state_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [OUT_WIDTH-1:0] in_first;
    logic [OUT_WIDTH-1:0] hold_second;

    assign in_first    = OUT_WIDTH'(in_data >> FIRST_SHIFT);
    // Second beat always comes from the captured word, never from in_data.
    assign hold_second = OUT_WIDTH'(hold_q >> SECOND_SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    hold_d  = in_data;
                    data_d  = in_first;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (out_ready) begin
                    data_d  = hold_second;
                    last_d  = 1'b1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                // Accepting while the last beat leaves keeps the stream bubble-free.
                in_ready = out_ready;
                if (out_ready) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (in_valid) begin
                        hold_d  = in_data;
                        data_d  = in_first;
                        last_d  = 1'b0;
                        state_d = ST_HI;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_EMPTY;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                state_d = ST_EMPTY;
            end
        endcase
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign word_count = cnt_q;

endmodule

// File: tb/tb_st_word_splitter.sv
// Self-checking bench for st_word_splitter (MSB_FIRST=1, CNT_WIDTH=4).
module tb_st_word_splitter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_ready;
    logic        in_valid = 1'b0;
    logic [35:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [17:0] out_data;
    logic        out_last;
    logic [3:0]  word_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    st_word_splitter #(
        .OUT_WIDTH(18),
        .IN_WIDTH (36),
        .MSB_FIRST(1'b1),
        .CNT_WIDTH(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_ready  (in_ready),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .word_count(word_count)
    );

    // Reference model: queue of beats still owed downstream.
    typedef struct {
        logic [17:0] d;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned m_wc = 0;

    typedef struct {
        logic        iv;
        logic [35:0] d;
        logic        ordy;
        logic        e_valid;
        logic [17:0] e_data;
        logic        e_last;
        logic        e_ir;
        logic [3:0]  e_wc;
    } vec_t;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic step(input logic iv, input logic [35:0] id, input logic ordy, output logic acc);
        logic  exp_ir;
        logic  emit;
        beat_t b;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        exp_ir = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
        chk("in_ready", 36'(in_ready), 36'(exp_ir));
        chk("out_valid", 36'(out_valid), 36'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_data", 36'(out_data), 36'(exp_q[0].d));
            chk("out_last", 36'(out_last), 36'(exp_q[0].last));
        end
        chk("word_count", 36'(word_count), 36'(m_wc % 16));
        acc  = iv && exp_ir;
        emit = (exp_q.size() != 0) && ordy;
        @(posedge clk);
        if (emit) begin
            if (exp_q[0].last) m_wc++;
            void'(exp_q.pop_front());
        end
        if (acc) begin
            b.d = 18'(id / 36'd262144);   b.last = 1'b0; exp_q.push_back(b);
            b.d = 18'(id % 36'd262144);   b.last = 1'b1; exp_q.push_back(b);
        end
        @(negedge clk);
    endtask

    // Present n words back-to-back with out_ready=1; returns cycles spent.
    task automatic send_words(input int unsigned n, input logic [35:0] base, output int unsigned cyc);
        int unsigned sent = 0;
        logic        acc;
        cyc = 0;
        while (sent < n && cyc < 4 * n + 8) begin
            step(1'b1, base + 36'(sent) * 36'h0_0004_0001, 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        if (sent < n) chk("send_timeout", 36'(sent), 36'(n));
    endtask

    task automatic drain(input int unsigned n);
        logic acc;
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, acc);
    endtask

    initial begin
        vec_t        vecs[7];
        logic        acc;
        int unsigned cyc;

        vecs[0] = '{1'b0, 36'h0,           1'b1, 1'b0, 18'h0,     1'b0, 1'b1, 4'd0};
        vecs[1] = '{1'b1, 36'h9_ABCD_1234, 1'b0, 1'b0, 18'h0,     1'b0, 1'b1, 4'd0};
        vecs[2] = '{1'b0, 36'h0,           1'b0, 1'b1, 18'h26AF3, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{1'b0, 36'h0,           1'b1, 1'b1, 18'h26AF3, 1'b0, 1'b0, 4'd0};
        vecs[4] = '{1'b1, 36'hF_FFFF_FFFF, 1'b0, 1'b1, 18'h11234, 1'b1, 1'b0, 4'd0};
        vecs[5] = '{1'b0, 36'h0,           1'b1, 1'b1, 18'h11234, 1'b1, 1'b1, 4'd0};
        vecs[6] = '{1'b0, 36'h0,           1'b1, 1'b0, 18'h0,     1'b0, 1'b1, 4'd1};

        // Reset then idle.
        #12;
        chk("rst_in_ready", 36'(in_ready), 36'd1);
        chk("rst_out_valid", 36'(out_valid), 36'd0);
        chk("rst_out_data", 36'(out_data), 36'd0);
        chk("rst_out_last", 36'(out_last), 36'd0);
        chk("rst_word_count", 36'(word_count), 36'd0);
        #13;
        reset_n = 1'b1;
        @(negedge clk);

        // Single word with stalls in HI and LO, table-driven.
        foreach (vecs[i]) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            #1;
            chk("vec_out_valid", 36'(out_valid), 36'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk("vec_out_data", 36'(out_data), 36'(vecs[i].e_data));
                chk("vec_out_last", 36'(out_last), 36'(vecs[i].e_last));
            end
            chk("vec_in_ready", 36'(in_ready), 36'(vecs[i].e_ir));
            chk("vec_word_count", 36'(word_count), 36'(vecs[i].e_wc));
            @(posedge clk);
            @(negedge clk);
        end
        m_wc = 1;

        // Back-to-back stream of 8 incrementing words.
        send_words(8, 36'h1_0000_0001, cyc);
        chk("b2b_accept_cycles", 36'(cyc), 36'd15);
        drain(3);
        chk("b2b_word_count", 36'(word_count), 36'd9);

        // Stall three cycles in HI and in LO.
        step(1'b1, 36'hA_5A5A_5A5A, 1'b1, acc);
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 36'h3_3333_3333, 1'b0, acc);
        step(1'b0, '0, 1'b1, acc);
        for (int unsigned i = 0; i < 3; i++) step(1'b1, 36'h3_3333_3333, 1'b0, acc);
        drain(2);

        // Reset while in LO.
        step(1'b1, 36'hC_0FFE_E123, 1'b1, acc);
        step(1'b0, '0, 1'b1, acc);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 36'(out_valid), 36'd0);
        chk("midrst_out_last", 36'(out_last), 36'd0);
        chk("midrst_in_ready", 36'(in_ready), 36'd1);
        chk("midrst_word_count", 36'(word_count), 36'd0);
        exp_q.delete();
        m_wc = 0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 36'h5_1234_5678, 1'b1, acc);
        drain(3);

        // Counter wrap: 17 words into a 4-bit counter after one word above.
        send_words(17, 36'h0_0000_0100, cyc);
        drain(3);
        chk("wrap_word_count", 36'(word_count), 36'd2);

        // Randomized traffic against the model.
        for (int unsigned i = 0; i < 400; i++) begin
            step(1'($urandom), {4'($urandom), 32'($urandom)}, ($urandom % 4) != 0, acc);
        end
        drain(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
